cmd_queue_master: RTL and testbench
===================================

CMD_QUEUE_MASTER -- requirements
Module: cmd_queue_master

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO entries, power of two, 2..16.
REQ-002 Parameter ADDR_W, default 16: bus address width.
REQ-003 Parameter DATA_W, default 8: bus data width.
REQ-004 Parameter TIMEOUT, default 255: maximum cycles waited for ack or read data, excluding split wait.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_ready  out  1  FIFO can accept a command.
REQ-009 cmd_rw  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  ADDR_W  target address.
REQ-011 cmd_wdata  in  DATA_W  write data; ignored for reads.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
REQ-014 rsp_err  out  1  completion by timeout.
REQ-015 m_req  out  1  bus request.
REQ-016 m_grant  in  1  bus grant.
REQ-017 m_address_out / m_address_out_valid  out  ADDR_W / 1  address phase.
REQ-018 m_data_out / m_data_out_valid  out  DATA_W / 1  write data phase.
REQ-019 m_rw  out  1  direction of current transfer.
REQ-020 m_ready  out  1  master can accept read data.
REQ-021 m_ack, m_split_ack, m_data_in_valid  in  1 each; m_data_in  in  DATA_W.

Function
REQ-022 Push occurs when cmd_valid && cmd_ready; cmd_ready = (count != DEPTH), independent of a same-cycle pop.
REQ-023 Pop occurs only in state RESP; a simultaneous push and pop leaves count unchanged.
REQ-024 FSM states are IDLE, REQ, ADDR, WDATA, WAIT_ACK, WAIT_RDATA, SPLIT_WAIT, RESP.
REQ-025 IDLE -> REQ when the FIFO is non-empty; the head entry is latched into the transfer registers on this transition.
REQ-026 m_req is 1 in REQ, ADDR, WDATA, WAIT_ACK and WAIT_RDATA, and 0 in all other states.
REQ-027 REQ -> ADDR on m_grant; no timeout applies in REQ.
REQ-028 In ADDR, m_address_out_valid is 1 for exactly one cycle; writes then go to WDATA and reads go to WAIT_ACK.
REQ-029 In WDATA, m_data_out_valid is 1 for exactly one cycle; the state then goes to WAIT_ACK.
REQ-030 In WAIT_ACK, m_ack moves writes to RESP and reads to WAIT_RDATA.
REQ-031 In WAIT_ACK, m_split_ack moves to SPLIT_WAIT and takes priority over m_ack in the same cycle.
REQ-032 WAIT_RDATA -> RESP on m_data_in_valid, capturing m_data_in.
REQ-033 SPLIT_WAIT -> RESP on m_data_in_valid, capturing m_data_in; no timeout applies in SPLIT_WAIT.
REQ-034 A timeout counter clears on entry to WAIT_ACK or WAIT_RDATA.
REQ-035 When the timeout counter reaches TIMEOUT, the state goes to RESP with rsp_err=1 and rsp_rdata=0.
REQ-036 In RESP, rsp_valid is 1 for one cycle, the head entry pops, and the state returns to IDLE.
REQ-037 rsp outputs are registered, and rsp_rdata holds its value until the next rsp_valid.
REQ-038 m_ready is 1 in WAIT_ACK, WAIT_RDATA and SPLIT_WAIT, and 0 otherwise.
REQ-039 m_address_out, m_data_out and m_rw hold the latched values from REQ through RESP, and are 0 in IDLE.
REQ-040 m_data_in_valid outside WAIT_RDATA and SPLIT_WAIT is ignored.
REQ-041 FIFO pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.

Reset
REQ-042 On rst_n low, the FSM goes to IDLE and count, pointers and the timeout counter go to 0.
REQ-043 On rst_n low, every output goes to 0 except cmd_ready, which goes to 1.
REQ-044 Reset mid-transfer abandons the transfer and discards all queued commands, with no rsp_valid pulse.

Structure
REQ-045 Shared package bus_pkg holds ADDR_W, DATA_W and the FSM state enum type.
REQ-046 One sub-module, cmd_fifo (synchronous FIFO: push, pop, full, empty, count), stores {rw, addr, wdata}.

Verification
REQ-047 Write 0x4004/0xA7 with grant after 2 cycles and ack 1 cycle after data -> address and data pulses present; rsp_valid with rsp_err=0.
REQ-048 Read 0x4004, with ack then m_data_in=0xA7 -> rsp_rdata=0xA7 and exactly one rsp_valid pulse.
REQ-049 Read 0x8004 answered with split_ack, then data 0x5E after 20 cycles -> m_req drops in SPLIT_WAIT; rsp_rdata=0x5E, rsp_err=0.
REQ-050 Five back-to-back commands with DEPTH=4 -> cmd_ready=0 after the 4th push; all commands complete in order.
REQ-051 Read with no ack for 255 cycles -> rsp_err=1, rsp_rdata=0, FSM in IDLE; the next command proceeds normally.
REQ-052 rst_n pulsed low in WAIT_ACK with 3 commands queued -> all outputs at reset values, cmd_ready=1, no rsp_valid pulse.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared bus widths and command master FSM state encoding
package bus_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  typedef enum logic [2:0] {
    IDLE, REQ, ADDR, WDATA, WAIT_ACK, WAIT_RDATA, SPLIT_WAIT, RESP
  } st_e;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO holding queued bus commands
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wptr_q] <= wdata;
  assign rdata = mem_q[rptr_q];
  assign full  = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
endmodule

// File: rtl/cmd_queue_master.sv
// cmd_queue_master: queues commands and replays them one at a time on a split-capable bus
module cmd_queue_master #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = bus_pkg::ADDR_W,
  parameter int DATA_W  = bus_pkg::DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              m_req,
  input  logic              m_grant,
  output logic [ADDR_W-1:0] m_address_out,
  output logic              m_address_out_valid,
  output logic [DATA_W-1:0] m_data_out,
  output logic              m_data_out_valid,
  output logic              m_rw,
  output logic              m_ready,
  input  logic              m_ack,
  input  logic              m_split_ack,
  input  logic              m_data_in_valid,
  input  logic [DATA_W-1:0] m_data_in
);
  import bus_pkg::*;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = 1 + ADDR_W + DATA_W;
  st_e               state_q, state_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [FW-1:0]     head;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              waiting, timed_out, to_err;
  cmd_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid && !fifo_full),
    .pop   (state_q == RESP),
    .wdata ({cmd_rw, cmd_addr, cmd_wdata}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
  always_comb begin
    waiting     = state_q == WAIT_ACK || state_q == WAIT_RDATA;
    timed_out   = waiting && tcnt_q == TW'(TIMEOUT);
    to_err      = 1'b0;
    state_d     = state_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        state_d = REQ;
        {rw_d, addr_d, wdata_d} = head;
      end
      REQ:   if (m_grant) state_d = ADDR;
      ADDR:  state_d = rw_q ? WDATA : WAIT_ACK;
      WDATA: state_d = WAIT_ACK;
      WAIT_ACK:
        if (m_split_ack) state_d = SPLIT_WAIT;
        else if (m_ack) state_d = rw_q ? RESP : WAIT_RDATA;
        else if (timed_out) begin
          state_d = RESP;
          to_err  = 1'b1;
        end
      WAIT_RDATA:
        if (m_data_in_valid) state_d = RESP;
        else if (timed_out) begin
          state_d = RESP;
          to_err  = 1'b1;
        end
      SPLIT_WAIT: if (m_data_in_valid) state_d = RESP;
      default: state_d = IDLE;
    endcase
    rsp_valid_d = state_d == RESP;
    if (rsp_valid_d) begin
      rsp_err_d   = to_err;
      rsp_rdata_d = (to_err || rw_q) ? '0 : m_data_in;
    end
    tcnt_d = (waiting && state_d == state_q) ? tcnt_q + TW'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  assign cmd_ready           = fifo_count != CW'(DEPTH);
  assign rsp_valid           = rsp_valid_q;
  assign rsp_err             = rsp_err_q;
  assign rsp_rdata           = rsp_rdata_q;
  assign m_req               = state_q inside {REQ, ADDR, WDATA, WAIT_ACK, WAIT_RDATA};
  assign m_ready             = state_q inside {WAIT_ACK, WAIT_RDATA, SPLIT_WAIT};
  assign m_address_out_valid = state_q == ADDR;
  assign m_data_out_valid    = state_q == WDATA;
  assign m_address_out       = state_q == IDLE ? '0 : addr_q;
  assign m_data_out          = state_q == IDLE ? '0 : wdata_q;
  assign m_rw                = state_q == IDLE ? 1'b0 : rw_q;
endmodule

// File: tb/tb_cmd_queue_master.sv
// tb_cmd_queue_master: directed checks of queueing, bus phases, split, timeout and reset
module tb_cmd_queue_master;
  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic        m_req, m_grant, m_address_out_valid, m_data_out_valid, m_rw, m_ready;
  logic [15:0] m_address_out;
  logic [7:0]  m_data_out, m_data_in;
  logic        m_ack, m_split_ack, m_data_in_valid;
  int          total, bad, pulses, k, p0, n, i;
  logic        auto, mon, r;
  logic [7:0]  exp_rd [5];

  cmd_queue_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_req(m_req), .m_grant(m_grant),
    .m_address_out(m_address_out), .m_address_out_valid(m_address_out_valid),
    .m_data_out(m_data_out), .m_data_out_valid(m_data_out_valid),
    .m_rw(m_rw), .m_ready(m_ready), .m_ack(m_ack), .m_split_ack(m_split_ack),
    .m_data_in_valid(m_data_in_valid), .m_data_in(m_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    m_grant = 0; m_ack = 0; m_split_ack = 0; m_data_in_valid = 0; m_data_in = 0;
  endtask

  // one cycle: lands on the falling edge, then plays an always-willing slave if enabled
  task automatic step();
    @(negedge clk);
    if (auto) begin
      m_grant = m_req;
      m_ack = m_ready;
      m_data_in_valid = m_ready;
      m_data_in = m_address_out[7:0] ^ 8'h3C;
    end
    if (rsp_valid) begin
      pulses++;
      if (mon && k < 5) begin
        chk("order", rsp_rdata, exp_rd[k]);
        k++;
      end
    end
  endtask

  task automatic push(input logic rw, input logic [15:0] a, input logic [7:0] d);
    cmd_valid = 1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
    step();
    cmd_valid = 0;
  endtask

  initial begin
    total = 0; bad = 0; pulses = 0; k = 0; auto = 0; mon = 0;
    exp_rd = '{8'h3D, 8'h3E, 8'h00, 8'h38, 8'h39};
    rst_n = 0; cmd_valid = 0; cmd_rw = 0; cmd_addr = 0; cmd_wdata = 0;
    bus_idle();
    step(); step();
    chk("rst_flags", {m_req, m_ready, rsp_valid, rsp_err, m_address_out_valid, m_data_out_valid, m_rw, cmd_ready}, 8'b0000_0001);
    chk("rst_addr", m_address_out, 0);
    rst_n = 1;

    push(1, 16'h4004, 8'hA7);
    chk("wr_idle_req", m_req, 0);
    step();
    chk("wr_req", {m_req, m_address_out_valid}, 2'b10);
    step();
    chk("wr_req_hold", m_req, 1);
    m_grant = 1;
    step();
    m_grant = 0;
    chk("wr_addr_ph", {m_address_out_valid, m_rw, m_data_out_valid}, 3'b110);
    chk("wr_addr", m_address_out, 16'h4004);
    step();
    chk("wr_data_ph", {m_data_out_valid, m_address_out_valid}, 2'b10);
    chk("wr_data", m_data_out, 8'hA7);
    step();
    chk("wr_wait", {m_ready, m_data_out_valid, m_req}, 3'b101);
    m_ack = 1;
    step();
    m_ack = 0;
    chk("wr_rsp", {rsp_valid, rsp_err, m_req}, 3'b100);
    chk("wr_rdata", rsp_rdata, 0);
    step();
    chk("wr_done", {rsp_valid, m_req, m_rw}, 3'b000);
    chk("wr_idle_addr", m_address_out, 0);

    p0 = pulses;
    push(0, 16'h4004, 8'h00);
    step();
    m_grant = 1;
    step();
    m_grant = 0;
    chk("rd_addr_ph", {m_address_out_valid, m_rw}, 2'b10);
    step();
    chk("rd_wait", {m_data_out_valid, m_ready}, 2'b01);
    m_ack = 1;
    step();
    m_ack = 0;
    chk("rd_wrdata", {m_req, m_ready}, 2'b11);
    m_data_in_valid = 1; m_data_in = 8'hA7;
    step();
    bus_idle();
    chk("rd_rsp", {rsp_valid, rsp_err}, 2'b10);
    chk("rd_rdata", rsp_rdata, 8'hA7);
    repeat (5) step();
    chk("rd_pulses", pulses - p0, 1);
    chk("rd_hold", rsp_rdata, 8'hA7);

    push(0, 16'h8004, 8'h00);
    step();
    m_grant = 1;
    step();
    m_grant = 0;
    step();
    m_split_ack = 1; m_ack = 1;
    step();
    bus_idle();
    chk("sp_wait", {m_req, m_ready}, 2'b01);
    repeat (19) step();
    chk("sp_still", {rsp_valid, m_ready, m_req}, 3'b010);
    m_data_in_valid = 1; m_data_in = 8'h5E;
    step();
    bus_idle();
    chk("sp_rsp", {rsp_valid, rsp_err}, 2'b10);
    chk("sp_rdata", rsp_rdata, 8'h5E);
    step();

    auto = 1; mon = 1; k = 0; i = 0;
    for (int g = 0; g < 50 && i < 5; g++) begin
      cmd_valid = 1; cmd_rw = (i == 2); cmd_addr = 16'h1001 + 16'(i); cmd_wdata = 8'h50 + 8'(i);
      r = cmd_ready;
      step();
      if (r) begin
        i++;
        if (i == 4) chk("full_ready", cmd_ready, 0);
      end
    end
    cmd_valid = 0;
    chk("pushed", i, 5);
    for (int g = 0; g < 200 && k < 5; g++) step();
    chk("drained", k, 5);
    mon = 0; auto = 0;
    bus_idle();
    step(); step();

    push(0, 16'h2002, 8'h00);
    step();
    m_grant = 1;
    step();
    m_grant = 0;
    step();
    chk("to_wait", m_ready, 1);
    n = 0;
    while (!rsp_valid && n < 400) begin
      step();
      n++;
    end
    chk("to_lat", n >= 255 && n <= 257, 1);
    chk("to_rsp", {rsp_valid, rsp_err}, 2'b11);
    chk("to_rdata", rsp_rdata, 0);
    step();
    chk("to_idle", {m_req, m_ready, rsp_valid}, 3'b000);
    chk("to_idle_addr", m_address_out, 0);
    auto = 1;
    push(0, 16'h1010, 8'h00);
    for (int g = 0; g < 30; g++) begin
      step();
      if (rsp_valid) break;
    end
    chk("next_rsp", {rsp_valid, rsp_err}, 2'b10);
    chk("next_rdata", rsp_rdata, 8'h2C);
    auto = 0;
    bus_idle();
    step();

    for (int j = 0; j < 3; j++) begin
      cmd_valid = 1; cmd_rw = 0; cmd_addr = 16'h3000 + 16'(j); cmd_wdata = 0;
      step();
    end
    cmd_valid = 0;
    m_grant = 1;
    for (int g = 0; g < 20 && !m_ready; g++) step();
    m_grant = 0;
    chk("mid_wait", m_ready, 1);
    p0 = pulses;
    #1 rst_n = 0;
    #1;
    chk("mid_rst_flags", {m_req, m_ready, rsp_valid, rsp_err, m_address_out_valid, m_data_out_valid, m_rw, cmd_ready}, 8'b0000_0001);
    chk("mid_rst_rdata", rsp_rdata, 0);
    chk("mid_rst_addr", m_address_out, 0);
    step(); step();
    rst_n = 1;
    repeat (10) step();
    chk("mid_no_pulse", pulses - p0, 0);
    chk("mid_discard", {m_req, cmd_ready}, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
